// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencing controller.
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Selects the operation for a start request; multiply wins a tie.
  function automatic logic start_op(input logic mult, input logic div);
    return (div && !mult) ? OP_DIV : OP_MULT;
  endfunction

endpackage

// File: rtl/multdiv_step_counter.sv
// Iteration counter for the multiply/divide sequencer: loadable, clearable,
// saturating at STEPS-1 where it raises its terminal-count flag.
module multdiv_step_counter #(
  parameter int unsigned STEPS = 32
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   sclr,
  input  logic                   ld,
  input  logic [$clog2(STEPS):0] ld_val,
  input  logic                   en,
  output logic [$clog2(STEPS):0] cnt,
  output logic                   tc_c
);

  localparam int unsigned      CNT_W = $clog2(STEPS) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEPS - 1);

  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_we;

  // Priority: clear, load, then count; holds once the terminal count is reached.
  always_comb begin
    cnt_nxt = cnt;
    cnt_we  = 1'b0;
    if (sclr) begin
      cnt_nxt = '0;
      cnt_we  = 1'b1;
    end else if (ld) begin
      cnt_nxt = ld_val;
      cnt_we  = 1'b1;
    end else if (en && !tc_c) begin
      cnt_nxt = cnt + CNT_W'(1);
      cnt_we  = 1'b1;
    end
  end

  // Enabled register cell with asynchronous active-high clear.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= '0;
    end else if (cnt_we) begin
      cnt <= cnt_nxt;
    end
  end

  assign tc_c = (cnt == LAST);

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the iterative multiply/divide unit: LOAD, STEPS
// RUN iterations, then a one-cycle DONE carrying the exception flag and tag.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEPS = WIDTH,
  parameter int unsigned TAG_W = 5
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   ctrl_mult,
  input  logic                   ctrl_div,
  input  logic [TAG_W-1:0]       dst_tag_in,
  input  logic                   divisor_zero,
  input  logic                   mult_ovf,
  input  logic                   flush,
  output logic                   load_ops,
  output logic                   step_en,
  output logic                   is_div,
  output logic [$clog2(STEPS):0] step_cnt,
  output logic                   busy,
  output logic                   stall,
  output logic                   result_rdy,
  output logic                   exception,
  output logic [TAG_W-1:0]       dst_tag_out
);

  localparam int unsigned CNT_W = $clog2(STEPS) + 1;

  state_e           state, state_nxt;
  logic             start;
  logic             accept;
  logic             is_div_nxt;
  logic             exc_nxt;
  logic [TAG_W-1:0] tag_nxt;
  logic             cnt_tc_c;
  logic             cnt_sclr;
  logic             cnt_ld;
  logic             cnt_en;

  assign start  = ctrl_mult | ctrl_div;
  // Starts are only honoured when idle or finishing, and never alongside a flush.
  assign accept = start && !flush && (state == ST_IDLE || state == ST_DONE);

  // Next-state and latched-operand logic.
  always_comb begin
    state_nxt  = state;
    is_div_nxt = is_div;
    tag_nxt    = dst_tag_out;
    exc_nxt    = exception;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (is_div && divisor_zero) begin
          state_nxt = ST_DONE;
          exc_nxt   = 1'b1;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_tc_c) begin
          state_nxt = ST_DONE;
          if (!is_div) exc_nxt = mult_ovf;
        end
      end
      ST_DONE: begin
        state_nxt = start ? ST_LOAD : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (accept) begin
      is_div_nxt = start_op(ctrl_mult, ctrl_div);
      tag_nxt    = dst_tag_in;
      exc_nxt    = 1'b0;
    end
    if (flush) begin
      state_nxt = ST_IDLE;
      exc_nxt   = 1'b0;
    end
  end

  // State, latched operands and state-decoded outputs, all registered.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= ST_IDLE;
      is_div      <= OP_MULT;
      dst_tag_out <= '0;
      exception   <= 1'b0;
      load_ops    <= 1'b0;
      step_en     <= 1'b0;
      busy        <= 1'b0;
      stall       <= 1'b0;
      result_rdy  <= 1'b0;
    end else begin
      state       <= state_nxt;
      is_div      <= is_div_nxt;
      dst_tag_out <= tag_nxt;
      exception   <= exc_nxt;
      load_ops    <= (state_nxt == ST_LOAD);
      step_en     <= (state_nxt == ST_RUN);
      busy        <= (state_nxt != ST_IDLE);
      stall       <= (state_nxt == ST_LOAD) || (state_nxt == ST_RUN);
      result_rdy  <= (state_nxt == ST_DONE);
    end
  end

  // Counter is zeroed on entry to LOAD and held at STEPS-1 through DONE.
  assign cnt_sclr = (state_nxt == ST_IDLE);
  assign cnt_ld   = (state_nxt == ST_LOAD);
  assign cnt_en   = (state == ST_RUN);

  multdiv_step_counter #(
    .STEPS (STEPS)
  ) u_step_counter (
    .clk    (clk),
    .clr    (~clr_n),
    .sclr   (cnt_sclr),
    .ld     (cnt_ld),
    .ld_val (CNT_W'(0)),
    .en     (cnt_en),
    .cnt    (step_cnt),
    .tc_c   (cnt_tc_c)
  );

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: stimulus queues expected results, a
// negedge monitor checks each result_rdy pulse against the queue head.
module tb_multdiv_ctrl;

  localparam int unsigned STEPS = 32;
  localparam int unsigned TAG_W = 5;
  localparam int unsigned CW    = $clog2(STEPS) + 1;
  localparam int          LAT   = STEPS + 2;

  logic             clk = 1'b0;
  logic             clr_n = 1'b0;
  logic             ctrl_mult = 1'b0;
  logic             ctrl_div = 1'b0;
  logic [TAG_W-1:0] dst_tag_in = '0;
  logic             divisor_zero = 1'b0;
  logic             mult_ovf = 1'b0;
  logic             flush = 1'b0;
  logic             load_ops, step_en, is_div, busy, stall, result_rdy, exception;
  logic [CW-1:0]    step_cnt;
  logic [TAG_W-1:0] dst_tag_out;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic             exc;
    logic             div;
    int               start_cyc;
    int               lat;
    int               steps;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_rdy = 0;
  int   step_seen = 0;
  int   stall_seen = 0;

  multdiv_ctrl #(
    .WIDTH (32),
    .STEPS (STEPS),
    .TAG_W (TAG_W)
  ) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .ctrl_mult    (ctrl_mult),
    .ctrl_div     (ctrl_div),
    .dst_tag_in   (dst_tag_in),
    .divisor_zero (divisor_zero),
    .mult_ovf     (mult_ovf),
    .flush        (flush),
    .load_ops     (load_ops),
    .step_en      (step_en),
    .is_div       (is_div),
    .step_cnt     (step_cnt),
    .busy         (busy),
    .stall        (stall),
    .result_rdy   (result_rdy),
    .exception    (exception),
    .dst_tag_out  (dst_tag_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Monitor: counts RUN/stall cycles per operation and scores each result.
  always @(negedge clk) begin
    if (clr_n) begin
      if (load_ops) begin
        step_seen  = 0;
        stall_seen = 0;
      end
      if (step_en) step_seen++;
      if (stall) stall_seen++;
      if (result_rdy) begin
        n_rdy++;
        check("rdy_expected", longint'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rdy_tag", dst_tag_out, e.tag);
          check("rdy_exception", exception, e.exc);
          check("rdy_is_div", is_div, e.div);
          check("rdy_latency", cyc - e.start_cyc, e.lat);
          check("rdy_run_cycles", step_seen, e.steps);
          check("rdy_stall_cycles", stall_seen, e.steps + 1);
          check("rdy_stall_low", stall, 0);
          check("rdy_busy", busy, 1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic m, input logic d, input logic [TAG_W-1:0] tag,
                       input bit push, input logic exc, input int lat, input int steps);
    exp_t x;
    ctrl_mult  = m;
    ctrl_div   = d;
    dst_tag_in = tag;
    if (push) begin
      x.tag       = tag;
      x.exc       = exc;
      x.div       = d & ~m;
      x.start_cyc = cyc;
      x.lat       = lat;
      x.steps     = steps;
      sb.push_back(x);
    end
  endtask

  task automatic release_start();
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
  endtask

  initial begin
    int r;
    int t;
    // Reset values
    tick(2);
    check("reset_ctrl", {load_ops, step_en, is_div, busy, stall, result_rdy, exception}, 0);
    check("reset_step_cnt", step_cnt, 0);
    check("reset_tag", dst_tag_out, 0);
    clr_n = 1'b1;
    tick(2);

    // Multiply, early mult_ovf pulse must be ignored
    issue(1, 0, 5'd7, 1, 0, LAT, STEPS);
    tick(1); release_start();
    check("mul_load", {load_ops, stall, step_en}, 3'b110);
    check("mul_tag", dst_tag_out, 7);
    check("mul_is_div", is_div, 0);
    tick(1);
    check("mul_run_first", {step_en, load_ops}, 2'b10);
    check("mul_cnt_first", step_cnt, 0);
    tick(8); mult_ovf = 1'b1;
    tick(1); mult_ovf = 1'b0;
    tick(22);
    check("mul_cnt_last", step_cnt, STEPS - 1);
    check("mul_run_last", step_en, 1);
    tick(1);
    check("mul_cnt_done", step_cnt, STEPS - 1);
    check("mul_done_ctrl", {step_en, stall, busy}, 3'b001);
    tick(1);
    check("mul_idle", {busy, stall, result_rdy}, 0);
    check("mul_cnt_idle", step_cnt, 0);
    tick(2);

    // Divide by zero: straight from LOAD to DONE
    divisor_zero = 1'b1;
    issue(0, 1, 5'd3, 1, 1, 2, 0);
    tick(1); release_start();
    check("dz_load", {load_ops, is_div}, 2'b11);
    tick(1);
    check("dz_no_step", step_en, 0);
    divisor_zero = 1'b0;
    tick(2);

    // Multiply overflow on the last RUN cycle only
    issue(1, 0, 5'd9, 1, 1, LAT, STEPS);
    tick(1); release_start();
    tick(4); mult_ovf = 1'b1;
    tick(1); mult_ovf = 1'b0;
    tick(27); mult_ovf = 1'b1;
    tick(1); mult_ovf = 1'b0;
    tick(2);

    // Back-to-back: divide issued in the DONE cycle of a multiply
    issue(1, 0, 5'd12, 1, 0, LAT, STEPS);
    tick(1); release_start();
    tick(33);
    issue(0, 1, 5'd20, 1, 0, LAT, STEPS);
    tick(1); release_start();
    check("b2b_load", {load_ops, is_div}, 2'b11);
    check("b2b_tag", dst_tag_out, 20);
    tick(34);

    // Flush at step_cnt == 10
    issue(1, 0, 5'd4, 0, 0, LAT, STEPS);
    tick(1); release_start();
    tick(11);
    check("fl_cnt_at_flush", step_cnt, 10);
    flush = 1'b1;
    tick(1); flush = 1'b0;
    check("fl_idle", {busy, stall, step_en}, 0);
    check("fl_cnt", step_cnt, 0);
    check("fl_exc", exception, 0);
    r = n_rdy;
    tick(40);
    check("fl_no_rdy", n_rdy, r);

    // Flush together with a start drops the start
    flush = 1'b1;
    issue(1, 0, 5'd8, 0, 0, LAT, STEPS);
    tick(1); release_start(); flush = 1'b0;
    check("flst_idle", {busy, load_ops}, 0);
    tick(2);

    // Simultaneous multiply and divide: multiply wins
    issue(1, 1, 5'd15, 1, 0, LAT, STEPS);
    tick(1); release_start();
    check("sim_is_div", is_div, 0);
    check("sim_load", load_ops, 1);
    tick(35);

    // Asynchronous reset mid-RUN
    issue(0, 1, 5'd6, 0, 0, LAT, STEPS);
    tick(1); release_start();
    tick(9);
    check("rst_pre_busy", busy, 1);
    clr_n = 1'b0;
    #1;
    check("rst_ctrl", {load_ops, step_en, is_div, busy, stall, result_rdy, exception}, 0);
    check("rst_cnt", step_cnt, 0);
    check("rst_tag", dst_tag_out, 0);
    #2 clr_n = 1'b1;
    r = n_rdy;
    tick(1);
    check("rst_stays_idle", busy, 0);
    tick(40);
    check("rst_no_rdy", n_rdy, r);

    // Drain any outstanding expectations with a bounded wait
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      tick(1);
      t++;
    end
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
